// File: rtl/axi_sram_arbiter.sv
// Two-master to one-slave AXI4 arbiter in front of axi_sram. The read (AR/R) and
// write (AW/W/B) paths each hold a round-robin grant for one whole transaction.
module axi_sram_arbiter #(
  parameter int DATA_WIDTH = 32,
  parameter int ADDR_WIDTH = 32,
  parameter int ID_WIDTH   = 4,
  parameter int STRB_WIDTH = DATA_WIDTH / 8
) (
  input  logic                  i_clk,
  input  logic                  i_rst_n,
  // master 0 (instruction fetch)
  input  logic [ID_WIDTH-1:0]   s0_axi_arid,
  input  logic [ADDR_WIDTH-1:0] s0_axi_araddr,
  input  logic [7:0]            s0_axi_arlen,
  input  logic [2:0]            s0_axi_arsize,
  input  logic [1:0]            s0_axi_arburst,
  input  logic                  s0_axi_arvalid,
  output logic                  s0_axi_arready,
  output logic [ID_WIDTH-1:0]   s0_axi_rid,
  output logic [DATA_WIDTH-1:0] s0_axi_rdata,
  output logic [1:0]            s0_axi_rresp,
  output logic                  s0_axi_rlast,
  output logic                  s0_axi_rvalid,
  input  logic                  s0_axi_rready,
  input  logic [ID_WIDTH-1:0]   s0_axi_awid,
  input  logic [ADDR_WIDTH-1:0] s0_axi_awaddr,
  input  logic [7:0]            s0_axi_awlen,
  input  logic [2:0]            s0_axi_awsize,
  input  logic [1:0]            s0_axi_awburst,
  input  logic                  s0_axi_awvalid,
  output logic                  s0_axi_awready,
  input  logic [DATA_WIDTH-1:0] s0_axi_wdata,
  input  logic [STRB_WIDTH-1:0] s0_axi_wstrb,
  input  logic                  s0_axi_wlast,
  input  logic                  s0_axi_wvalid,
  output logic                  s0_axi_wready,
  output logic [ID_WIDTH-1:0]   s0_axi_bid,
  output logic [1:0]            s0_axi_bresp,
  output logic                  s0_axi_bvalid,
  input  logic                  s0_axi_bready,
  // master 1 (load/store unit)
  input  logic [ID_WIDTH-1:0]   s1_axi_arid,
  input  logic [ADDR_WIDTH-1:0] s1_axi_araddr,
  input  logic [7:0]            s1_axi_arlen,
  input  logic [2:0]            s1_axi_arsize,
  input  logic [1:0]            s1_axi_arburst,
  input  logic                  s1_axi_arvalid,
  output logic                  s1_axi_arready,
  output logic [ID_WIDTH-1:0]   s1_axi_rid,
  output logic [DATA_WIDTH-1:0] s1_axi_rdata,
  output logic [1:0]            s1_axi_rresp,
  output logic                  s1_axi_rlast,
  output logic                  s1_axi_rvalid,
  input  logic                  s1_axi_rready,
  input  logic [ID_WIDTH-1:0]   s1_axi_awid,
  input  logic [ADDR_WIDTH-1:0] s1_axi_awaddr,
  input  logic [7:0]            s1_axi_awlen,
  input  logic [2:0]            s1_axi_awsize,
  input  logic [1:0]            s1_axi_awburst,
  input  logic                  s1_axi_awvalid,
  output logic                  s1_axi_awready,
  input  logic [DATA_WIDTH-1:0] s1_axi_wdata,
  input  logic [STRB_WIDTH-1:0] s1_axi_wstrb,
  input  logic                  s1_axi_wlast,
  input  logic                  s1_axi_wvalid,
  output logic                  s1_axi_wready,
  output logic [ID_WIDTH-1:0]   s1_axi_bid,
  output logic [1:0]            s1_axi_bresp,
  output logic                  s1_axi_bvalid,
  input  logic                  s1_axi_bready,
  // toward the SRAM
  output logic [ID_WIDTH-1:0]   m_axi_arid,
  output logic [ADDR_WIDTH-1:0] m_axi_araddr,
  output logic [7:0]            m_axi_arlen,
  output logic [2:0]            m_axi_arsize,
  output logic [1:0]            m_axi_arburst,
  output logic                  m_axi_arlock,
  output logic [3:0]            m_axi_arcache,
  output logic [2:0]            m_axi_arprot,
  output logic                  m_axi_arvalid,
  input  logic                  m_axi_arready,
  input  logic [ID_WIDTH-1:0]   m_axi_rid,
  input  logic [DATA_WIDTH-1:0] m_axi_rdata,
  input  logic [1:0]            m_axi_rresp,
  input  logic                  m_axi_rlast,
  input  logic                  m_axi_rvalid,
  output logic                  m_axi_rready,
  output logic [ID_WIDTH-1:0]   m_axi_awid,
  output logic [ADDR_WIDTH-1:0] m_axi_awaddr,
  output logic [7:0]            m_axi_awlen,
  output logic [2:0]            m_axi_awsize,
  output logic [1:0]            m_axi_awburst,
  output logic                  m_axi_awlock,
  output logic [3:0]            m_axi_awcache,
  output logic [2:0]            m_axi_awprot,
  output logic                  m_axi_awvalid,
  input  logic                  m_axi_awready,
  output logic [DATA_WIDTH-1:0] m_axi_wdata,
  output logic [STRB_WIDTH-1:0] m_axi_wstrb,
  output logic                  m_axi_wlast,
  output logic                  m_axi_wvalid,
  input  logic                  m_axi_wready,
  input  logic [ID_WIDTH-1:0]   m_axi_bid,
  input  logic [1:0]            m_axi_bresp,
  input  logic                  m_axi_bvalid,
  output logic                  m_axi_bready
);

  typedef enum logic [1:0] {R_IDLE, R_ADDR, R_DATA} rd_state_t;
  typedef enum logic [1:0] {W_IDLE, W_ADDR, W_DATA, W_RESP} wr_state_t;

  rd_state_t r_rd_state, w_rd_state_next;
  wr_state_t r_wr_state, w_wr_state_next;
  logic      r_rd_gnt, w_rd_gnt_next, r_rd_last, w_rd_last_next;
  logic      r_wr_gnt, w_wr_gnt_next, r_wr_last, w_wr_last_next;
  logic      w_rready_sel, w_wvalid_sel, w_wlast_sel, w_bready_sel;

  assign m_axi_arlock  = 1'b0;
  assign m_axi_arcache = 4'd0;
  assign m_axi_arprot  = 3'd0;
  assign m_axi_awlock  = 1'b0;
  assign m_axi_awcache = 4'd0;
  assign m_axi_awprot  = 3'd0;

  assign w_rready_sel = r_rd_gnt ? s1_axi_rready : s0_axi_rready;
  assign w_wvalid_sel = r_wr_gnt ? s1_axi_wvalid : s0_axi_wvalid;
  assign w_wlast_sel  = r_wr_gnt ? s1_axi_wlast  : s0_axi_wlast;
  assign w_bready_sel = r_wr_gnt ? s1_axi_bready : s0_axi_bready;

  // last=1 out of reset so s0 wins the first tie on both paths
  always_ff @(posedge i_clk or negedge i_rst_n) begin
    if (!i_rst_n) begin
      r_rd_state <= R_IDLE;
      r_rd_gnt   <= 1'b0;
      r_rd_last  <= 1'b1;
      r_wr_state <= W_IDLE;
      r_wr_gnt   <= 1'b0;
      r_wr_last  <= 1'b1;
    end else begin
      r_rd_state <= w_rd_state_next;
      r_rd_gnt   <= w_rd_gnt_next;
      r_rd_last  <= w_rd_last_next;
      r_wr_state <= w_wr_state_next;
      r_wr_gnt   <= w_wr_gnt_next;
      r_wr_last  <= w_wr_last_next;
    end
  end

  always_comb begin
    w_rd_state_next = r_rd_state;
    w_rd_gnt_next   = r_rd_gnt;
    w_rd_last_next  = r_rd_last;
    m_axi_arid      = '0;
    m_axi_araddr    = '0;
    m_axi_arlen     = '0;
    m_axi_arsize    = '0;
    m_axi_arburst   = '0;
    m_axi_arvalid   = 1'b0;
    s0_axi_arready  = 1'b0;
    s1_axi_arready  = 1'b0;
    m_axi_rready    = 1'b0;
    s0_axi_rid      = '0;
    s0_axi_rdata    = '0;
    s0_axi_rresp    = '0;
    s0_axi_rlast    = 1'b0;
    s0_axi_rvalid   = 1'b0;
    s1_axi_rid      = '0;
    s1_axi_rdata    = '0;
    s1_axi_rresp    = '0;
    s1_axi_rlast    = 1'b0;
    s1_axi_rvalid   = 1'b0;
    case (r_rd_state)
      R_IDLE: begin
        if (s0_axi_arvalid || s1_axi_arvalid) begin
          w_rd_state_next = R_ADDR;
          w_rd_gnt_next   = (s0_axi_arvalid && s1_axi_arvalid) ? ~r_rd_last : s1_axi_arvalid;
        end
      end
      R_ADDR: begin
        if (r_rd_gnt) begin
          m_axi_arid     = s1_axi_arid;
          m_axi_araddr   = s1_axi_araddr;
          m_axi_arlen    = s1_axi_arlen;
          m_axi_arsize   = s1_axi_arsize;
          m_axi_arburst  = s1_axi_arburst;
          m_axi_arvalid  = s1_axi_arvalid;
          s1_axi_arready = m_axi_arready;
        end else begin
          m_axi_arid     = s0_axi_arid;
          m_axi_araddr   = s0_axi_araddr;
          m_axi_arlen    = s0_axi_arlen;
          m_axi_arsize   = s0_axi_arsize;
          m_axi_arburst  = s0_axi_arburst;
          m_axi_arvalid  = s0_axi_arvalid;
          s0_axi_arready = m_axi_arready;
        end
        if ((r_rd_gnt ? s1_axi_arvalid : s0_axi_arvalid) && m_axi_arready)
          w_rd_state_next = R_DATA;
      end
      R_DATA: begin
        m_axi_rready = w_rready_sel;
        if (r_rd_gnt) begin
          s1_axi_rid    = m_axi_rid;
          s1_axi_rdata  = m_axi_rdata;
          s1_axi_rresp  = m_axi_rresp;
          s1_axi_rlast  = m_axi_rlast;
          s1_axi_rvalid = m_axi_rvalid;
        end else begin
          s0_axi_rid    = m_axi_rid;
          s0_axi_rdata  = m_axi_rdata;
          s0_axi_rresp  = m_axi_rresp;
          s0_axi_rlast  = m_axi_rlast;
          s0_axi_rvalid = m_axi_rvalid;
        end
        if (m_axi_rvalid && w_rready_sel && m_axi_rlast) begin
          w_rd_last_next  = r_rd_gnt;
          w_rd_state_next = R_IDLE;
        end
      end
      default: w_rd_state_next = R_IDLE;
    endcase
  end

  // W beats are blocked until the AW of the same master has been accepted
  always_comb begin
    w_wr_state_next = r_wr_state;
    w_wr_gnt_next   = r_wr_gnt;
    w_wr_last_next  = r_wr_last;
    m_axi_awid      = '0;
    m_axi_awaddr    = '0;
    m_axi_awlen     = '0;
    m_axi_awsize    = '0;
    m_axi_awburst   = '0;
    m_axi_awvalid   = 1'b0;
    s0_axi_awready  = 1'b0;
    s1_axi_awready  = 1'b0;
    m_axi_wdata     = '0;
    m_axi_wstrb     = '0;
    m_axi_wlast     = 1'b0;
    m_axi_wvalid    = 1'b0;
    s0_axi_wready   = 1'b0;
    s1_axi_wready   = 1'b0;
    m_axi_bready    = 1'b0;
    s0_axi_bid      = '0;
    s0_axi_bresp    = '0;
    s0_axi_bvalid   = 1'b0;
    s1_axi_bid      = '0;
    s1_axi_bresp    = '0;
    s1_axi_bvalid   = 1'b0;
    case (r_wr_state)
      W_IDLE: begin
        if (s0_axi_awvalid || s1_axi_awvalid) begin
          w_wr_state_next = W_ADDR;
          w_wr_gnt_next   = (s0_axi_awvalid && s1_axi_awvalid) ? ~r_wr_last : s1_axi_awvalid;
        end
      end
      W_ADDR: begin
        if (r_wr_gnt) begin
          m_axi_awid     = s1_axi_awid;
          m_axi_awaddr   = s1_axi_awaddr;
          m_axi_awlen    = s1_axi_awlen;
          m_axi_awsize   = s1_axi_awsize;
          m_axi_awburst  = s1_axi_awburst;
          m_axi_awvalid  = s1_axi_awvalid;
          s1_axi_awready = m_axi_awready;
        end else begin
          m_axi_awid     = s0_axi_awid;
          m_axi_awaddr   = s0_axi_awaddr;
          m_axi_awlen    = s0_axi_awlen;
          m_axi_awsize   = s0_axi_awsize;
          m_axi_awburst  = s0_axi_awburst;
          m_axi_awvalid  = s0_axi_awvalid;
          s0_axi_awready = m_axi_awready;
        end
        if ((r_wr_gnt ? s1_axi_awvalid : s0_axi_awvalid) && m_axi_awready)
          w_wr_state_next = W_DATA;
      end
      W_DATA: begin
        m_axi_wdata  = r_wr_gnt ? s1_axi_wdata : s0_axi_wdata;
        m_axi_wstrb  = r_wr_gnt ? s1_axi_wstrb : s0_axi_wstrb;
        m_axi_wlast  = w_wlast_sel;
        m_axi_wvalid = w_wvalid_sel;
        if (r_wr_gnt) s1_axi_wready = m_axi_wready;
        else          s0_axi_wready = m_axi_wready;
        if (w_wvalid_sel && m_axi_wready && w_wlast_sel)
          w_wr_state_next = W_RESP;
      end
      W_RESP: begin
        m_axi_bready = w_bready_sel;
        if (r_wr_gnt) begin
          s1_axi_bid    = m_axi_bid;
          s1_axi_bresp  = m_axi_bresp;
          s1_axi_bvalid = m_axi_bvalid;
        end else begin
          s0_axi_bid    = m_axi_bid;
          s0_axi_bresp  = m_axi_bresp;
          s0_axi_bvalid = m_axi_bvalid;
        end
        if (m_axi_bvalid && w_bready_sel) begin
          w_wr_last_next  = r_wr_gnt;
          w_wr_state_next = W_IDLE;
        end
      end
      default: w_wr_state_next = W_IDLE;
    endcase
  end

endmodule
